my_pipe_reg: RTL
================

// Module: my_pipe_reg
// PURPOSE
//   Parametrised N-stage pipeline register with valid/ready flow control, bubble
//   collapse and synchronous flush. Successor to the single-stage enable registers.
//   Sits between datapath units that can stall, e.g. a multiplier feeding an
//   accumulator. Replaces hand-chained enable registers and their external valid logic.
// PARAMETERS
//   DATA_WIDTH  24  width of DIN/DOUT payload
//   DEPTH       2   number of register stages (>=1); unstalled latency in cycles
//   CNT_W       $clog2(DEPTH+1)  width of COUNT (derived, do not override)
// PORTS
//   CLK        in   1           rising-edge clock
//   SRST_N     in   1           synchronous reset, active low
//   FLUSH      in   1           synchronous clear of all stages, priority over traffic
//   IN_VALID   in   1           upstream word valid
//   IN_READY   out  1           block accepts DIN this cycle
//   DIN        in   DATA_WIDTH  upstream payload
//   OUT_VALID  out  1           DOUT holds a valid word
//   OUT_READY  in   1           downstream accepts DOUT this cycle
//   DOUT       out  DATA_WIDTH  payload of last stage
//   COUNT      out  CNT_W       number of valid stages, 0..DEPTH
// BEHAVIOUR
//   - State: per stage k (0=input side, DEPTH-1=output) valid bit v[k], data d[k].
//   - Reset (SRST_N=0 at CLK edge): all v[k]=0, all d[k]=0. Outputs after reset:
//     OUT_VALID=0, DOUT=0, COUNT=0, IN_READY=1 (when FLUSH=0). Reset beats FLUSH.
//   - Advance: adv[DEPTH-1] = v[DEPTH-1] & OUT_READY & !FLUSH;
//     adv[k] = v[k] & (!v[k+1] | adv[k+1]) for k<DEPTH-1.
//   - Load: stage k+1 loads d[k] when adv[k]; stage 0 loads DIN when IN_VALID & IN_READY.
//   - IN_READY = !FLUSH & (!v[0] | adv[0]); combinational through the ready chain.
//   - OUT_VALID = v[DEPTH-1] & !FLUSH. DOUT = d[DEPTH-1] (registered, no comb path).
//   - Bubbles collapse: a word moves forward whenever the next stage is empty or
//     emptying, so a stalled output fills all DEPTH stages before IN_READY drops.
//   - Data regs load only on transfer; a held stage keeps its data bit-for-bit.
//     Invalid stages keep stale data; DOUT is don't-care while OUT_VALID=0.
//   - Throughput: 1 word/cycle with OUT_READY=1; latency DIN->DOUT = DEPTH cycles.
//   - Full (COUNT=DEPTH) with OUT_READY=1: simultaneous in/out allowed, COUNT stays.
//   - Empty: OUT_VALID=0; OUT_READY ignored.
//   - FLUSH=1 at edge: all v[k] cleared next cycle; no handshake completes in that
//     cycle (IN_READY=0, OUT_VALID=0); data regs unchanged.
//   - COUNT = popcount(v), registered-state derived, updates cycle after transfer.
//   - DEPTH=1: single stage; IN_READY=!v[0]|OUT_READY, full throughput retained.
//   - No protocol checks: IN_VALID may drop without transfer; no word is lost or
//     duplicated under any OUT_READY pattern.
// TESTING (DATA_WIDTH=24, DEPTH=3 unless stated)
//   1 Reset: SRST_N=0 2 cycles with IN_VALID=1 -> OUT_VALID=0, COUNT=0, DOUT=0;
//     first word 0x000001 after release appears on DOUT 3 cycles later.
//   2 Streaming: 0x000001..0x000010 back-to-back, OUT_READY=1 -> same order,
//     one per cycle, 3-cycle latency, IN_READY never 0.
//   3 Backpressure: OUT_READY=0 while feeding 0xA00000+i -> accepts exactly 3 words,
//     COUNT=3, IN_READY=0; OUT_READY=1 -> 0xA00000,0xA00001,0xA00002 drain in order.
//   4 Full, simultaneous in/out: COUNT=3, IN_VALID=OUT_READY=1 for 5 cycles ->
//     COUNT stays 3, 5 words out, 5 in, none lost.
//   5 Flush mid-stream: FLUSH=1 one cycle with COUNT=2 -> next cycle COUNT=0,
//     OUT_VALID=0; flushed words never appear; next word 0x123456 passes normally.
//   6 Random OUT_READY/IN_VALID 10k cycles, DEPTH=1 and DEPTH=5 -> scoreboard
//     match, COUNT equals model occupancy every cycle.

Source files
------------

// File: rtl/my_pipe_reg.sv
// N-stage valid/ready pipeline register with bubble collapse and synchronous flush.
// Each stage moves forward whenever the stage ahead is empty or emptying in the same cycle.
module my_pipe_reg #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_srst_n,
    input  logic                  i_flush,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0]      o_count
);

    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      w_adv;
    logic [DEPTH-1:0]      w_valid_d;
    logic                  w_in_fire;
    logic [CNT_W-1:0]      w_count;

    // Ready ripples from the output stage back towards stage 0.
    always_comb begin : adv_chain
        logic w_room;
        w_adv  = '0;
        w_room = i_out_ready & ~i_flush;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k] = r_valid[k] & w_room;
            w_room   = ~r_valid[k] | w_adv[k];
        end
    end

    assign o_in_ready = ~i_flush & (~r_valid[0] | w_adv[0]);
    assign w_in_fire  = i_in_valid & o_in_ready;

    always_comb begin
        w_valid_d    = r_valid;
        w_valid_d[0] = w_in_fire | (r_valid[0] & ~w_adv[0]);
        for (int k = 1; k < DEPTH; k++) begin
            w_valid_d[k] = w_adv[k-1] | (r_valid[k] & ~w_adv[k]);
        end
        if (i_flush) begin
            w_valid_d = '0;
        end
    end

    // Lower stages may still see adv during a flush; their data must stay put.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_d;
            if (w_in_fire) begin
                r_data[0] <= i_din;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k-1] && !i_flush) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_count = w_count + CNT_W'(r_valid[k]);
        end
    end

    assign o_out_valid = r_valid[DEPTH-1] & ~i_flush;
    assign o_dout      = r_data[DEPTH-1];
    assign o_count     = w_count;

endmodule
